// File: rtl/control_unit.sv
// Multi-cycle sequencer for the executee datapath.
// Fetch, decode, execute, memory and branch phases driven from irout and flags.
module control_unit #(
  parameter logic [3:0] ALU_PASSB = 4'h7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] irout,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  input  logic        mem_ready,
  output logic        en,
  output logic        sel,
  output logic        pc_sel,
  output logic        pc_load,
  output logic        pc_inc,
  output logic        ir_load,
  output logic        add_sel,
  output logic [2:0]  write_add,
  output logic [2:0]  fir_add,
  output logic [2:0]  sec_add,
  output logic [3:0]  opcode,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, BRANCH, HALT
  } state_t;

  state_t     state;
  logic [3:0] op;
  logic       is_alu;
  logic       is_mem;
  logic       is_hlt;
  logic       unused;

  assign op     = irout[15:12];
  assign is_alu = ~op[3];
  assign is_mem = (op == 4'h8) || (op == 4'h9);
  assign is_hlt = (op == 4'hF);
  // low IR bits only carry the branch offset, which the datapath consumes
  assign unused = ^irout[2:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:   state <= FETCH;
        FETCH:  if (mem_ready) state <= DECODE;
        DECODE: begin
          unique case (1'b1)
            is_alu:  state <= EXEC;
            is_mem:  state <= MEM;
            is_hlt:  state <= HALT;
            default: state <= BRANCH;
          endcase
        end
        EXEC:   state <= FETCH;
        MEM:    if (mem_ready) state <= FETCH;
        BRANCH: state <= FETCH;
        HALT:   state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    en        = 1'b0;
    sel       = 1'b0;
    pc_sel    = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    ir_load   = 1'b0;
    add_sel   = 1'b0;
    write_add = 3'd0;
    fir_add   = 3'd0;
    sec_add   = 3'd0;
    opcode    = 4'd0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    halted    = 1'b0;
    if (state != IDLE && state != HALT) begin
      write_add = irout[11:9];
      fir_add   = irout[8:6];
      sec_add   = irout[5:3];
    end
    case (state)
      FETCH: begin
        mem_rd  = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
      end
      EXEC: begin
        opcode = op;
        en     = 1'b1;
      end
      MEM: begin
        add_sel = 1'b1;
        if (op == 4'h9) begin
          mem_wr = 1'b1;
          opcode = ALU_PASSB;
        end else begin
          mem_rd = 1'b1;
          sel    = mem_ready;
          en     = mem_ready;
        end
      end
      BRANCH: begin
        case (op)
          4'hA: pc_load = 1'b1;
          4'hB: pc_load = Z;
          4'hC: pc_load = N;
          4'hD: pc_load = C;
          4'hE: begin
            opcode  = ALU_PASSB;
            pc_sel  = 1'b1;
            pc_load = 1'b1;
          end
          default: pc_load = 1'b0;
        endcase
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected traces from ISA rules.
// Randomized instructions, wait states and flags; directed boundary cases.
module tb_control_unit;

  typedef struct packed {
    logic       en, sel, pc_sel, pc_load, pc_inc, ir_load, add_sel;
    logic [2:0] wa, fa, sa;
    logic [3:0] op;
    logic       rd, wr, hl;
  } cu_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] irout = 16'h0;
  logic        C = 1'b0, N = 1'b0, Z = 1'b0;
  logic        mem_ready = 1'b0;
  logic        en, sel, pc_sel, pc_load, pc_inc, ir_load, add_sel;
  logic [2:0]  write_add, fir_add, sec_add;
  logic [3:0]  opcode;
  logic        mem_rd, mem_wr, halted;

  cu_t         got;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] prev_ir = 16'h0;

  localparam logic [3:0] PASSB = 4'h7;

  control_unit dut (
    .clk(clk), .rst(rst), .irout(irout),
    .C(C), .N(N), .Z(Z), .mem_ready(mem_ready),
    .en(en), .sel(sel), .pc_sel(pc_sel),
    .pc_load(pc_load), .pc_inc(pc_inc),
    .ir_load(ir_load), .add_sel(add_sel),
    .write_add(write_add), .fir_add(fir_add),
    .sec_add(sec_add), .opcode(opcode),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .halted(halted)
  );

  always #5 clk = ~clk;

  assign got = {en, sel, pc_sel, pc_load, pc_inc,
                ir_load, add_sel, write_add, fir_add,
                sec_add, opcode, mem_rd, mem_wr, halted};

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input cu_t g, input cu_t e);
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, g, e);
    end
  endtask

  function automatic cu_t fields(input logic [15:0] ir);
    cu_t e = '0;
    e.wa = ir[11:9];
    e.fa = ir[8:6];
    e.sa = ir[5:3];
    return e;
  endfunction

  task automatic noise();
    C = 1'($urandom);
    N = 1'($urandom);
    Z = 1'($urandom);
  endtask

  // check outputs mid-cycle, then advance past the next edge
  task automatic step(input string tag, input cu_t e);
    @(negedge clk);
    check(tag, got, e);
    @(posedge clk);
    #1;
  endtask

  // rst low across three edges, then one idle cycle before FETCH
  task automatic do_reset();
    rst = 1'b0;
    noise();
    mem_ready = 1'($urandom);
    @(posedge clk);
    #1;
    step("rst_low1", '0);
    step("rst_low2", '0);
    rst = 1'b1;
    mem_ready = 1'($urandom);
    step("idle", '0);
  endtask

  task automatic run_instr(input logic [15:0] ir,
                           input int wf, input int wm);
    cu_t e;
    logic [3:0] op = ir[15:12];
    logic taken;
    for (int w = 0; w <= wf; w++) begin
      mem_ready = (w == wf);
      noise();
      e = fields(prev_ir);
      e.rd = 1'b1;
      if (w == wf) begin
        e.ir_load = 1'b1;
        e.pc_inc  = 1'b1;
      end
      step("fetch", e);
    end
    irout = ir;
    prev_ir = ir;
    mem_ready = 1'($urandom);
    noise();
    step("decode", fields(ir));
    if (op <= 4'h7) begin
      mem_ready = 1'($urandom);
      noise();
      e = fields(ir);
      e.en = 1'b1;
      e.op = op;
      step("exec", e);
    end else if (op == 4'h8 || op == 4'h9) begin
      for (int w = 0; w <= wm; w++) begin
        mem_ready = (w == wm);
        noise();
        e = fields(ir);
        e.add_sel = 1'b1;
        if (op == 4'h9) begin
          e.wr = 1'b1;
          e.op = PASSB;
        end else begin
          e.rd = 1'b1;
          e.sel = (w == wm);
          e.en  = (w == wm);
        end
        step(op == 4'h9 ? "st" : "ld", e);
      end
    end else if (op == 4'hF) begin
      for (int k = 0; k < 5; k++) begin
        mem_ready = 1'($urandom);
        noise();
        e = '0;
        e.hl = 1'b1;
        step("halt", e);
      end
      do_reset();
    end else begin
      mem_ready = 1'($urandom);
      noise();
      case (op)
        4'hB:    taken = Z;
        4'hC:    taken = N;
        4'hD:    taken = C;
        default: taken = 1'b1;
      endcase
      e = fields(ir);
      e.pc_load = taken;
      if (op == 4'hE) begin
        e.pc_sel = 1'b1;
        e.op = PASSB;
      end
      step("branch", e);
    end
  endtask

  task automatic run_branch_flag(input logic [15:0] ir,
                                 input logic zf);
    cu_t e;
    for (int w = 0; w < 1; w++) begin
      mem_ready = 1'b1;
      e = fields(prev_ir);
      e.rd = 1'b1;
      e.ir_load = 1'b1;
      e.pc_inc = 1'b1;
      step("fetch", e);
    end
    irout = ir;
    prev_ir = ir;
    step("decode", fields(ir));
    Z = zf;
    C = 1'b1;
    N = 1'b1;
    e = fields(ir);
    e.pc_load = zf;
    step(zf ? "bz_taken" : "bz_not", e);
  endtask

  initial begin
    cu_t e;
    logic [15:0] ir;
    do_reset();
    // mid-FETCH reset with a pending read
    mem_ready = 1'b0;
    e = fields(prev_ir);
    e.rd = 1'b1;
    step("fetch_wait", e);
    do_reset();
    run_instr(16'h0298, 0, 0);
    run_instr(16'h8A80, 4, 2);
    run_instr(16'h9098, 0, 0);
    run_branch_flag(16'hB0FE, 1'b1);
    run_branch_flag(16'hB0FE, 1'b0);
    run_instr(16'hE018, 0, 0);
    run_instr(16'hF000, 1, 0);
    run_instr(16'h0298, 0, 0);
    for (int i = 0; i < 200; i++) begin
      ir = 16'($urandom);
      if (ir[15:12] == 4'hF && ($urandom_range(0, 3) != 0))
        ir[15:12] = 4'($urandom_range(0, 14));
      run_instr(ir, $urandom_range(0, 3),
                $urandom_range(0, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
